// File: rtl/game_pkg.sv
// game_pkg: state type and constants shared by the game timer and score blocks.
package game_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} timer_state_t;
    localparam int SECONDS_PER_MINUTE = 60;
    localparam int TIMER_W = 11;
endpackage

// File: rtl/bcd_mmss_counter.sv
// bcd_mmss_counter: two-digit BCD minutes and seconds with per-digit carry.
module bcd_mmss_counter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [7:0] min_bcd_o,
    output logic [7:0] sec_bcd_o
);
    logic [3:0] s0_q, s1_q, m0_q, m1_q, s0_d, s1_d, m0_d, m1_d;
    logic s0_wrap, s1_wrap, m0_wrap;
    always_comb begin
        s0_wrap = inc_i && s0_q == 4'd9;
        s1_wrap = s0_wrap && s1_q == 4'd5;
        m0_wrap = s1_wrap && m0_q == 4'd9;
        s0_d = clr_i ? 4'd0 : inc_i ? (s0_wrap ? 4'd0 : s0_q + 4'd1) : s0_q;
        s1_d = clr_i ? 4'd0 : s0_wrap ? (s1_wrap ? 4'd0 : s1_q + 4'd1) : s1_q;
        m0_d = clr_i ? 4'd0 : s1_wrap ? (m0_wrap ? 4'd0 : m0_q + 4'd1) : m0_q;
        m1_d = clr_i ? 4'd0 : m0_wrap ? (m1_q == 4'd9 ? 4'd0 : m1_q + 4'd1) : m1_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_q <= '0;
            s1_q <= '0;
            m0_q <= '0;
            m1_q <= '0;
        end else begin
            s0_q <= s0_d;
            s1_q <= s1_d;
            m0_q <= m0_d;
            m1_q <= m1_d;
        end
    end
    assign sec_bcd_o = {s1_q, s0_q};
    assign min_bcd_o = {m1_q, m0_q};
endmodule

// File: rtl/game_timer.sv
// game_timer: round timer with 1 s prescaler, saturating binary seconds and BCD mm:ss.
module game_timer
    import game_pkg::*;
#(
    parameter int CLK_FREQ_HZ        = 50_000_000,
    parameter int TIME_LIMIT_MINUTES = 30
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    output logic [TIMER_W-1:0] timer,
    output logic [7:0]         min_bcd,
    output logic [7:0]         sec_bcd,
    output logic               running,
    output logic               sec_tick,
    output logic               timed_out
);
    localparam int LIMIT = TIME_LIMIT_MINUTES * SECONDS_PER_MINUTE;
    localparam int PW = CLK_FREQ_HZ > 1 ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_FREQ_HZ - 1);
    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

    if (LIMIT > 2047 || TIME_LIMIT_MINUTES > 99) begin : g_bad_limit
        $error("game_timer: TIME_LIMIT_MINUTES out of range");
    end

    timer_state_t       state_q, state_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               tick_q, tick_d, to_q, to_d, run_q, clr, inc;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        timer_d = timer_q;
        to_d    = to_q;
        tick_d  = 1'b0;
        clr     = 1'b0;
        inc     = 1'b0;
        if (start) begin
            clr     = 1'b1;
            presc_d = '0;
            timer_d = '0;
            to_d    = 1'b0;
            state_d = pause ? PAUSED : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (stop) state_d = DONE;
                    else if (pause) state_d = PAUSED;
                    else if (presc_q == PRE_MAX) begin
                        presc_d = '0;
                        timer_d = timer_q + 1'b1;
                        tick_d  = 1'b1;
                        inc     = 1'b1;
                        // Hitting the limit ends the round on the same edge as the final tick.
                        if (timer_q == LAST) begin
                            state_d = DONE;
                            to_d    = 1'b1;
                        end
                    end else presc_d = presc_q + 1'b1;
                end
                PAUSED: state_d = stop ? DONE : pause ? PAUSED : RUN;
                default: presc_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            timer_q <= '0;
            tick_q  <= 1'b0;
            to_q    <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            timer_q <= timer_d;
            tick_q  <= tick_d;
            to_q    <= to_d;
            run_q   <= state_d == RUN;
        end
    end

    bcd_mmss_counter u_bcd (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_i    (clr),
        .inc_i    (inc),
        .min_bcd_o(min_bcd),
        .sec_bcd_o(sec_bcd)
    );

    assign timer     = timer_q;
    assign running   = run_q;
    assign sec_tick  = tick_q;
    assign timed_out = to_q;
endmodule

// File: tb/tb_game_timer.sv
// tb_game_timer: randomized and directed checks of game_timer against a cycle-count model.
module tb_game_timer;
    localparam int F = 4;
    localparam int LIM = 120;

    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0;
    logic [10:0] timer;
    logic [7:0] min_bcd, sec_bcd;
    logic running, sec_tick, timed_out;
    int total = 0, bad = 0;

    // Model: counted run cycles; elapsed seconds = run cycles / F. Mode 0 idle, 1 run, 2 paused, 3 done.
    int m_rc, m_secs, m_mode;
    bit m_tick, m_to;

    game_timer #(.CLK_FREQ_HZ(F), .TIME_LIMIT_MINUTES(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .pause(pause),
        .timer(timer), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .running(running), .sec_tick(sec_tick), .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [29:0] expv();
        return {11'(m_secs), to_bcd(m_secs / 60), to_bcd(m_secs % 60), m_mode == 1, m_tick, m_to};
    endfunction

    function automatic logic [29:0] obs();
        return {timer, min_bcd, sec_bcd, running, sec_tick, timed_out};
    endfunction

    task automatic m_reset();
        m_rc = 0; m_secs = 0; m_mode = 0; m_tick = 0; m_to = 0;
    endtask

    task automatic cyc(input logic st, input logic sp, input logic pa);
        start = st; stop = sp; pause = pa;
        @(posedge clk);
        m_tick = 0;
        if (st) begin
            m_rc = 0; m_secs = 0; m_to = 0; m_mode = pa ? 2 : 1;
        end else if ((m_mode == 1 || m_mode == 2) && sp) m_mode = 3;
        else if (m_mode == 1 && pa) m_mode = 2;
        else if (m_mode == 2 && !pa) m_mode = 1;
        else if (m_mode == 1) begin
            m_rc++;
            if (m_rc % F == 0) begin
                m_tick = 1;
                m_secs = m_rc / F;
                if (m_secs == LIM) begin m_mode = 3; m_to = 1; end
            end
        end
        #1;
        start = 0; stop = 0;
    endtask

    task automatic test_reset();
        m_reset();
        #12 reset_n = 1'b1;
        #1;
        if (obs() !== 30'h0) begin bad++; $display("FAIL reset: got %h expected %h", obs(), 30'h0); end
        total++;
        for (int i = 0; i < 6; i++) begin
            cyc(0, i[0], 1);
            if (obs() !== expv()) begin bad++; $display("FAIL idle_ignore: got %h expected %h", obs(), expv()); end
            total++;
        end
    endtask

    task automatic test_start_ticks();
        cyc(1, 0, 0);
        if (running !== 1'b1) begin bad++; $display("FAIL start_running: got %b expected 1", running); end
        total++;
        for (int i = 1; i <= 13; i++) begin
            cyc(0, 0, 0);
            if (obs() !== expv()) begin bad++; $display("FAIL start_tick c%0d: got %h expected %h", i, obs(), expv()); end
            total++;
            if (i == 4 && {sec_tick, timer, sec_bcd} !== {1'b1, 11'd1, 8'h01}) begin
                bad++; $display("FAIL first_tick: got %b/%0d/%h expected 1/1/01", sec_tick, timer, sec_bcd);
            end
            if (i == 4) total++;
        end
    endtask

    task automatic test_minute_carry();
        int n = 0;
        while (m_secs < 60 && n < 400) begin
            cyc(0, 0, 0);
            n++;
            if (obs() !== expv()) begin bad++; $display("FAIL carry: got %h expected %h", obs(), expv()); end
            total++;
        end
        if ({timer, min_bcd, sec_bcd} !== {11'd60, 8'h01, 8'h00}) begin
            bad++; $display("FAIL minute: got %0d %h:%h expected 60 01:00", timer, min_bcd, sec_bcd);
        end
        total++;
    endtask

    task automatic test_pause();
        int n = 0;
        while (!sec_tick && n < 10) begin cyc(0, 0, 0); n++; end
        if (!sec_tick) begin bad++; $display("FAIL pause_sync: got no tick expected tick"); end
        total++;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1);
            if (obs() !== expv()) begin bad++; $display("FAIL paused: got %h expected %h", obs(), expv()); end
            total++;
        end
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0);
            if (obs() !== expv()) begin bad++; $display("FAIL resume c%0d: got %h expected %h", i, obs(), expv()); end
            total++;
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        while (!m_to && n < 1000) begin
            cyc(0, 0, 0);
            n++;
            if (obs() !== expv()) begin bad++; $display("FAIL to_run: got %h expected %h", obs(), expv()); end
            total++;
        end
        for (int i = 0; i < 8; i++) cyc(0, 0, 0);
        if (obs() !== {11'd120, 8'h02, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            bad++; $display("FAIL timeout: got %h expected %h", obs(), {11'd120, 8'h02, 8'h00, 3'b001});
        end
        total++;
    endtask

    task automatic test_stop_on_tick();
        int n = 0;
        cyc(1, 0, 0);
        while (!(m_secs == 37 && m_rc % F == F - 1) && n < 400) begin cyc(0, 0, 0); n++; end
        cyc(0, 1, 0);
        if ({timer, sec_tick, running} !== {11'd37, 1'b0, 1'b0}) begin
            bad++; $display("FAIL stop_tick: got %0d/%b/%b expected 37/0/0", timer, sec_tick, running);
        end
        total++;
        for (int i = 0; i < 6; i++) cyc(0, 0, 0);
        if (obs() !== expv()) begin bad++; $display("FAIL stop_hold: got %h expected %h", obs(), expv()); end
        total++;
        cyc(1, 0, 1);
        if (obs() !== 30'h0) begin bad++; $display("FAIL start_paused: got %h expected %h", obs(), 30'h0); end
        total++;
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        if (obs() !== expv()) begin bad++; $display("FAIL paused_hold: got %h expected %h", obs(), expv()); end
        total++;
    endtask

    task automatic test_async_reset();
        cyc(1, 0, 0);
        for (int i = 0; i < 30; i++) cyc(0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        if (obs() !== 30'h0) begin bad++; $display("FAIL async_reset: got %h expected %h", obs(), 30'h0); end
        total++;
        m_reset();
        #2 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
        if (obs() !== expv()) begin bad++; $display("FAIL post_reset: got %h expected %h", obs(), expv()); end
        total++;
    endtask

    task automatic test_random();
        logic pa = 1'b0;
        cyc(1, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) pa = ~pa;
            cyc($urandom_range(299) == 0, $urandom_range(399) == 0, pa);
            if (obs() !== expv()) begin bad++; $display("FAIL random c%0d: got %h expected %h", i, obs(), expv()); end
            total++;
        end
    endtask

    initial begin
        test_reset();
        test_start_ticks();
        test_minute_carry();
        test_pause();
        test_timeout();
        test_stop_on_tick();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
